// File: rtl/mini16_s2m_arbiter_if.sv
// PE-side write request bus and s2m RAM write port of the round-robin arbiter.
// The slave modport is the arbiter; the master modport is the PE/RAM side.
interface mini16_s2m_arbiter_if #(
  parameter int CORES     = 4,
  parameter int WIDTH_D   = 32,
  parameter int DEPTH_S2M = 8,
  parameter int WIDTH_CNT = 16
);
  logic                         hold;
  logic [CORES-1:0]             req;
  logic [CORES*DEPTH_S2M-1:0]   req_addr;
  logic [CORES*WIDTH_D-1:0]     req_data;
  logic [CORES-1:0]             ack;
  logic                         mem_we;
  logic [DEPTH_S2M-1:0]         mem_addr;
  logic [WIDTH_D-1:0]           mem_din;
  logic [WIDTH_CNT-1:0]         stall_cnt;

  modport slave (
    input  hold, req, req_addr, req_data,
    output ack, mem_we, mem_addr, mem_din, stall_cnt
  );

  modport master (
    output hold, req, req_addr, req_data,
    input  ack, mem_we, mem_addr, mem_din, stall_cnt
  );
endinterface

// File: rtl/mini16_s2m_arbiter.sv
// Round-robin arbiter for the shared s2m RAM write port: one-hot combinational ack, registered write.
// Define MINI16_S2M_ARB_STATS_EN to build the saturating stall counter; otherwise stall_cnt is 0.
module mini16_s2m_arbiter #(
  parameter int CORES     = 4,
  parameter int WIDTH_D   = 32,
  parameter int DEPTH_S2M = 8,
  parameter int WIDTH_CNT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mini16_s2m_arbiter_if.slave  bus
);
  localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [CORES-1:0]     ack_c;
  logic                 mem_we_q;
  logic [DEPTH_S2M-1:0] mem_addr_q;
  logic [WIDTH_D-1:0]   mem_din_q;
  int                   idx;

  // Search starts one past the last winner so every requester waits at most CORES-1 grants.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    ack_c   = '0;
    idx     = 0;
    if (reset_n && !bus.hold) begin
      for (int k = 1; k <= CORES; k++) begin
        idx = (int'(rr_ptr) + k) % CORES;
        if (!gnt_vld && bus.req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    if (gnt_vld) ack_c[gnt_idx] = 1'b1;
  end

  assign bus.ack = ack_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= PTR_W'(CORES - 1);
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else if (gnt_vld) begin
      rr_ptr     <= gnt_idx;
      mem_we_q   <= 1'b1;
      mem_addr_q <= bus.req_addr[gnt_idx*DEPTH_S2M +: DEPTH_S2M];
      mem_din_q  <= bus.req_data[gnt_idx*WIDTH_D +: WIDTH_D];
    end else begin
      mem_we_q   <= 1'b0;
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;

`ifdef MINI16_S2M_ARB_STATS_EN
  logic [WIDTH_CNT-1:0] stall_q;

  // Hold cycles count too: any requester left waiting is a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if (|(bus.req & ~ack_c) && !(&stall_q))
      stall_q <= stall_q + 1'b1;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = {WIDTH_CNT{1'b0}};
`endif
endmodule
